vc_sched: RTL

VC_SCHED -- requirements
Module: vc_sched

---
 rtl/vc_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vc_sched.sv
// vc_sched: weighted round-robin scheduler draining two virtual-channel FIFOs.
// While both VCs hold data, VC0 gets WEIGHT0 consecutive pops and VC1 gets
// WEIGHT1 consecutive pops per turn. A destination pause parks the FSM in
// STALL and later resumes the interrupted state with its burst count intact.
// pop_main refills the VC FIFOs from the main FIFO while neither VC is above
// its pause threshold.
module vc_sched #(
    parameter int WEIGHT0 = 3,
    parameter int WEIGHT1 = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Main_fifo_empty,
    input  logic       VC0_empty,
    input  logic       VC1_empty,
    input  logic       VC0_pause,
    input  logic       VC1_pause,
    input  logic       D0_pause,
    input  logic       D1_pause,
    output logic       pop_main,
    output logic       pop_VC0,
    output logic       pop_VC1,
    output logic [1:0] state,
    output logic [7:0] pkt_cnt_VC0,
    output logic [7:0] pkt_cnt_VC1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2,
        STALL  = 2'd3
    } state_t;

    // Burst counter value at which a VC has used up its turn.
    localparam logic [3:0] LAST0 = 4'(WEIGHT0 - 1);
    localparam logic [3:0] LAST1 = 4'(WEIGHT1 - 1);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    logic [3:0] burst_q, burst_d;
    logic       dst_pause;

    assign dst_pause = D0_pause | D1_pause;
    assign state     = state_q;

    // Read strobes: main FIFO refills while no VC is above threshold; a VC
    // is popped only while it is being served and the destination accepts.
    assign pop_main = !reset && !(VC0_pause || VC1_pause) && !Main_fifo_empty;
    assign pop_VC0  = !reset && (state_q == SERVE0) && !dst_pause && !VC0_empty;
    assign pop_VC1  = !reset && (state_q == SERVE1) && !dst_pause && !VC1_empty;

    // State, burst and resume-point registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            saved_q <= IDLE;
            burst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic: pause first, then empty-VC hand-off, then burst end.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                burst_d = 4'd0;
                if (dst_pause) begin
                    state_d = STALL;
                    saved_d = IDLE;
                end else if (!VC0_empty) begin
                    state_d = SERVE0;
                end else if (!VC1_empty) begin
                    state_d = SERVE1;
                end
            end
            SERVE0: begin
                if (dst_pause) begin
                    state_d = STALL;
                    saved_d = SERVE0;
                end else if (VC0_empty) begin
                    state_d = VC1_empty ? IDLE : SERVE1;
                    burst_d = 4'd0;
                end else if (burst_q == LAST0) begin
                    state_d = VC1_empty ? SERVE0 : SERVE1;
                    burst_d = 4'd0;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end
            SERVE1: begin
                if (dst_pause) begin
                    state_d = STALL;
                    saved_d = SERVE1;
                end else if (VC1_empty) begin
                    state_d = VC0_empty ? IDLE : SERVE0;
                    burst_d = 4'd0;
                end else if (burst_q == LAST1) begin
                    state_d = VC0_empty ? SERVE1 : SERVE0;
                    burst_d = 4'd0;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end
            STALL: begin
                if (!dst_pause) begin
                    state_d = saved_q;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = 4'd0;
            end
        endcase
    end

    // Per-VC pop counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_VC0 <= 8'd0;
            pkt_cnt_VC1 <= 8'd0;
        end else begin
            if (pop_VC0) pkt_cnt_VC0 <= pkt_cnt_VC0 + 8'd1;
            if (pop_VC1) pkt_cnt_VC1 <= pkt_cnt_VC1 + 8'd1;
        end
    end

endmodule
